// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RX pin plus a falling-edge detector.
module uart_rx_sync (
    input  logic clk,
    input  logic res,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    // All flops come out of reset at the idle-high line level so no edge is invented.
    always_ff @(posedge clk) begin
        if (res) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
            prev_reg <= 1'b1;
        end else begin
            meta_reg <= rx;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign rx_s = sync_reg;
    assign fall = prev_reg & ~sync_reg;

endmodule

// File: rtl/uart_rx_param.sv
// UART receiver: idle qualification, mid-bit start validation, centre sampling
// of data/parity/stop bits, and a valid/ready word handover with error flags.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5000,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int IDLE_BITS    = 12
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int IDLE_W = $clog2(IDLE_BITS + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDLE_W-1:0] IDLE_DONE = IDLE_W'(IDLE_BITS);
    localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 8 ||
        (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) ||
        STOP_BITS < 1 || STOP_BITS > 2 || IDLE_BITS < 1) begin : g_bad_param
        $error("uart_rx_param: illegal parameter value");
    end

    logic rx_s;
    logic fall;

    uart_rx_sync u_sync (
        .clk  (clk),
        .res  (res),
        .rx   (RX),
        .rx_s (rx_s),
        .fall (fall)
    );

    rx_state_t            state_reg, state_next;
    logic [CNT_W-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [IDLE_W-1:0]    idle_cnt_reg, idle_cnt_next;
    logic [2:0]           data_cnt_reg, data_cnt_next;
    logic                 stop_cnt_reg, stop_cnt_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 perr_pend_reg, perr_pend_next;
    logic [DATA_BITS-1:0] data_out_reg, data_out_next;
    logic                 data_valid_reg, data_valid_next;
    logic                 parity_err_reg, parity_err_next;
    logic                 frame_err_reg, frame_err_next;
    logic                 overrun_reg, overrun_next;

    always_ff @(posedge clk) begin
        if (res) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= '0;
            idle_cnt_reg   <= '0;
            data_cnt_reg   <= '0;
            stop_cnt_reg   <= 1'b0;
            shift_reg      <= '0;
            perr_pend_reg  <= 1'b0;
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            idle_cnt_reg   <= idle_cnt_next;
            data_cnt_reg   <= data_cnt_next;
            stop_cnt_reg   <= stop_cnt_next;
            shift_reg      <= shift_next;
            perr_pend_reg  <= perr_pend_next;
            data_out_reg   <= data_out_next;
            data_valid_reg <= data_valid_next;
            parity_err_reg <= parity_err_next;
            frame_err_reg  <= frame_err_next;
            overrun_reg    <= overrun_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        idle_cnt_next   = idle_cnt_reg;
        data_cnt_next   = data_cnt_reg;
        stop_cnt_next   = stop_cnt_reg;
        shift_next      = shift_reg;
        perr_pend_next  = perr_pend_reg;
        data_out_next   = data_out_reg;
        data_valid_next = data_valid_reg;
        parity_err_next = parity_err_reg;
        frame_err_next  = 1'b0;
        overrun_next    = 1'b0;

        // Consumer handshake; a DONE cycle below may override this with a fresh word.
        if (data_valid_reg && data_ready) begin
            data_valid_next = 1'b0;
        end

        unique case (state_reg)
            IDLE: begin
                if (idle_cnt_reg == IDLE_DONE) begin
                    state_next = ARM;
                end else if (!rx_s) begin
                    bit_cnt_next  = '0;
                    idle_cnt_next = '0;
                end else if (bit_cnt_reg == CNT_LAST) begin
                    bit_cnt_next  = '0;
                    idle_cnt_next = idle_cnt_reg + 1'b1;
                end else begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
            ARM: begin
                if (fall) begin
                    state_next   = START;
                    bit_cnt_next = '0;
                end
            end
            START: begin
                if (bit_cnt_reg == CNT_HALF) begin
                    bit_cnt_next   = '0;
                    data_cnt_next  = '0;
                    perr_pend_next = 1'b0;
                    state_next     = rx_s ? ARM : DATA;
                end else begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
            DATA: begin
                if (bit_cnt_reg == CNT_LAST) begin
                    bit_cnt_next = '0;
                    shift_next   = {rx_s, shift_reg[DATA_BITS-1:1]};
                    if (data_cnt_reg == DATA_LAST) begin
                        stop_cnt_next = 1'b0;
                        state_next    = (PARITY == PAR_NONE) ? STOP : uart_pkg::PARITY;
                    end else begin
                        data_cnt_next = data_cnt_reg + 1'b1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
            uart_pkg::PARITY: begin
                if (bit_cnt_reg == CNT_LAST) begin
                    bit_cnt_next   = '0;
                    perr_pend_next = ((^shift_reg) ^ rx_s) != (PARITY == PAR_ODD);
                    state_next     = STOP;
                end else begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
            STOP: begin
                if (bit_cnt_reg == CNT_LAST) begin
                    bit_cnt_next = '0;
                    if (!rx_s) begin
                        // Broken frame: line state is suspect, so demand a full idle period again.
                        frame_err_next = 1'b1;
                        idle_cnt_next  = '0;
                        state_next     = IDLE;
                    end else if (stop_cnt_reg == STOP_LAST) begin
                        state_next = DONE;
                    end else begin
                        stop_cnt_next = 1'b1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
            DONE: begin
                if (!data_valid_reg || data_ready) begin
                    data_out_next   = shift_reg;
                    parity_err_next = perr_pend_reg;
                    data_valid_next = 1'b1;
                end else begin
                    overrun_next = 1'b1;
                end
                state_next = ARM;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;
    assign parity_err = parity_err_reg;
    assign frame_err  = frame_err_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_rx_param.sv
// Randomised scoreboard bench for uart_rx_param: three receiver configurations
// (8N1, 8E2, 7O1) share clock and reset; frames are built bit by bit here.
`timescale 1ns/1ps
module tb_uart_rx_param;

    localparam int CPB  = 16;
    localparam int IDLE = 4;
    localparam int NDUT = 3;

    function automatic int db_of(input int i);
        return (i == 2) ? 7 : 8;
    endfunction

    function automatic int par_of(input int i);
        return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
    endfunction

    function automatic int stop_of(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    logic clk = 1'b0;
    logic res = 1'b1;
    logic [NDUT-1:0] rx = '1;
    logic [NDUT-1:0] ready = '0;
    logic [NDUT-1:0][7:0] dout;
    logic [NDUT-1:0] dv;
    logic [NDUT-1:0] perr;
    logic [NDUT-1:0] ferr;
    logic [NDUT-1:0] ovr;

    int checks = 0;
    int passes = 0;
    int exp_q [NDUT][$];
    bit seen [NDUT] = '{default: 1'b0};
    bit dv_prev [NDUT] = '{default: 1'b0};
    int ferr_cnt [NDUT] = '{default: 0};
    int ovr_cnt [NDUT] = '{default: 0};

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        localparam int DB = db_of(gi);
        logic [DB-1:0] dout_w;

        uart_rx_param #(
            .CLKS_PER_BIT (CPB),
            .DATA_BITS    (DB),
            .PARITY       (par_of(gi)),
            .STOP_BITS    (stop_of(gi)),
            .IDLE_BITS    (IDLE)
        ) u_dut (
            .clk        (clk),
            .res        (res),
            .RX         (rx[gi]),
            .data_out   (dout_w),
            .data_valid (dv[gi]),
            .data_ready (ready[gi]),
            .parity_err (perr[gi]),
            .frame_err  (ferr[gi]),
            .overrun    (ovr[gi])
        );

        assign dout[gi] = 8'(dout_w);
    end

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act == expv) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    endtask

    // Monitor: a word is compared the first cycle it is presented.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NDUT; i++) begin
            if (res) begin
                seen[i]    = 1'b0;
                dv_prev[i] = 1'b0;
            end else begin
                if (dv_prev[i] && ready[i]) seen[i] = 1'b0;
                if (dv[i] && !seen[i]) begin
                    seen[i] = 1'b1;
                    if (exp_q[i].size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_word dut%0d: got 0x%0h expected none", i, dout[i]);
                    end else begin
                        int e;
                        e = exp_q[i].pop_front();
                        $display("rx dut%0d word 0x%0h perr %0d", i, dout[i], perr[i]);
                        check($sformatf("word_dut%0d", i), int'({perr[i], dout[i]}), e);
                    end
                end
                dv_prev[i] = dv[i];
                if (ferr[i]) ferr_cnt[i]++;
                if (ovr[i]) ovr_cnt[i]++;
            end
        end
    end

    task automatic drive_bit(input int i, input int v);
        rx[i] = v[0];
        repeat (CPB) @(negedge clk);
    endtask

    task automatic wait_bits(input int n);
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic pulse_ready(input int i);
        ready[i] = 1'b1;
        @(negedge clk);
        ready[i] = 1'b0;
    endtask

    // Reference: parity error when the count of ones (data + parity bit) breaks the mode's rule.
    task automatic send_frame(input int i, input int data, input int pbit,
                              input bit bad_stop, input bit expect_word);
        int ones;
        int perr_e;
        ones   = $countones(data) + pbit;
        perr_e = 0;
        if (par_of(i) == 1) perr_e = (ones % 2 == 0) ? 1 : 0;
        if (par_of(i) == 2) perr_e = (ones % 2 == 1) ? 1 : 0;
        if (expect_word) exp_q[i].push_back((perr_e << 8) | data);
        $display("tx dut%0d data 0x%0h pbit %0d bad_stop %0d", i, data, pbit, bad_stop);
        drive_bit(i, 0);
        for (int b = 0; b < db_of(i); b++) drive_bit(i, (data >> b) & 1);
        if (par_of(i) != 0) drive_bit(i, pbit);
        for (int s = 0; s < stop_of(i); s++)
            drive_bit(i, (bad_stop && s == stop_of(i) - 1) ? 0 : 1);
        rx[i] = 1'b1;
    endtask

    initial begin
        int d;
        int p;
        repeat (4) @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("rst_valid_dut%0d", i), int'(dv[i]), 0);
            check($sformatf("rst_dout_dut%0d", i), int'(dout[i]), 0);
            check($sformatf("rst_perr_dut%0d", i), int'(perr[i]), 0);
            check($sformatf("rst_ferr_dut%0d", i), int'(ferr[i]), 0);
            check($sformatf("rst_ovr_dut%0d", i), int'(ovr[i]), 0);
        end
        res = 1'b0;
        wait_bits(6);

        // 8N1 word, then one-cycle clear after ready
        send_frame(0, 'hA5, 0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("n1_valid", int'(dv[0]), 1);
        pulse_ready(0);
        check("n1_cleared", int'(dv[0]), 0);

        // even parity, bad then good parity bit
        ready[1] = 1'b1;
        send_frame(1, 'h03, 1, 1'b0, 1'b1);
        send_frame(1, 'h03, 0, 1'b0, 1'b1);

        // false start then a real frame without idle re-qualification
        rx[0] = 1'b0;
        repeat (6) @(negedge clk);
        rx[0] = 1'b1;
        wait_bits(2);
        check("false_start_no_valid", int'(dv[0]), 0);
        send_frame(0, 'h5A, 0, 1'b0, 1'b1);
        wait_bits(1);
        check("after_false_start_dout", int'(dout[0]), 'h5A);
        pulse_ready(0);

        // frame error on second stop bit; an early follow-up frame must be ignored
        send_frame(1, 'h77, 0, 1'b1, 1'b0);
        wait_bits(1);
        check("ferr_pulse", ferr_cnt[1], 1);
        send_frame(1, 'h00, 0, 1'b0, 1'b0);
        wait_bits(6);
        send_frame(1, 'h3C, 0, 1'b0, 1'b1);
        wait_bits(1);
        check("ferr_single", ferr_cnt[1], 1);

        // overrun with ready low
        send_frame(0, 'h11, 0, 1'b0, 1'b1);
        send_frame(0, 'h22, 0, 1'b0, 1'b0);
        wait_bits(1);
        check("ovr_pulse", ovr_cnt[0], 1);
        check("ovr_keep_dout", int'(dout[0]), 'h11);
        check("ovr_keep_valid", int'(dv[0]), 1);
        pulse_ready(0);

        // ready exactly in the delivery cycle: word replaced, no overrun
        send_frame(0, 'h11, 0, 1'b0, 1'b1);
        fork
            send_frame(0, 'h22, 0, 1'b0, 1'b1);
            begin
                repeat (2 + CPB / 2 + (8 + 1) * CPB + 1) @(posedge clk);
                @(negedge clk);
                ready[0] = 1'b1;
                @(negedge clk);
                ready[0] = 1'b0;
            end
        join
        wait_bits(1);
        check("done_hs_no_ovr", ovr_cnt[0], 1);
        check("done_hs_dout", int'(dout[0]), 'h22);
        pulse_ready(0);

        // randomised frames on all configurations
        ready = '1;
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < NDUT; i++) begin
                d = int'($urandom_range(0, (1 << db_of(i)) - 1));
                p = (par_of(i) != 0) ? int'($urandom_range(0, 1)) : 0;
                send_frame(i, d, p, 1'b0, 1'b1);
                wait_bits(int'($urandom_range(0, 2)));
            end
        end

        // reset during data bit 3 with a word pending
        ready[0] = 1'b0;
        send_frame(0, 'h99, 0, 1'b0, 1'b1);
        wait_bits(1);
        fork
            send_frame(0, 'h0F, 0, 1'b0, 1'b0);
            begin
                repeat (4 * CPB + CPB / 2) @(negedge clk);
                res = 1'b1;
                @(negedge clk);
                res = 1'b0;
                check("midrst_valid", int'(dv[0]), 0);
                check("midrst_dout", int'(dout[0]), 0);
                check("midrst_perr", int'(perr[0]), 0);
                check("midrst_ferr", int'(ferr[0]), 0);
                check("midrst_ovr", int'(ovr[0]), 0);
            end
        join
        wait_bits(6);
        ready[0] = 1'b1;
        send_frame(0, 'hC3, 0, 1'b0, 1'b1);
        wait_bits(2);

        for (int i = 0; i < NDUT; i++)
            check($sformatf("queue_empty_dut%0d", i), exp_q[i].size(), 0);
        check("ferr_total_dut0", ferr_cnt[0], 0);
        check("ferr_total_dut2", ferr_cnt[2], 0);
        check("ovr_total_dut1", ovr_cnt[1], 0);
        check("ovr_total_dut2", ovr_cnt[2], 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
